// File: rtl/sid_pot_sched.sv
// Round-robin scheduler sharing the SID POTX/POTY measurement pair between paddle ports.
// Switches the analog mux at discharge start, drops settling rounds, latches per-port X/Y.
package sid;
  localparam int unsigned PHASE_W   = 2;
  localparam int unsigned PHI1_PHI2 = 0;
  localparam int unsigned PHI2_PHI1 = 1;

  typedef logic [PHASE_W-1:0] phase_t;

  typedef struct packed {
    logic [1:0][7:0] xy;
  } pot_reg_t;
endpackage

module sid_pot_sched #(
  parameter int unsigned NPORTS        = 2,
  parameter int unsigned SETTLE_ROUNDS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  sid::phase_t          phase,
  input  logic                 discharge,
  input  sid::pot_reg_t        pot_reg,
  input  logic [NPORTS-1:0]    port_en,
  output logic [NPORTS-1:0]    port_sel,
  output logic [NPORTS*16-1:0] result,
  output logic [NPORTS-1:0]    valid,
  output logic                 upd,
  output logic [1:0]           upd_port
);
  localparam int unsigned SEL_W     = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam logic [1:0]  SETTLE_LD = 2'(SETTLE_ROUNDS);

  typedef enum logic [1:0] {SYNC, SETTLE, MEASURE} state_t;

  state_t            state, state_n;
  logic [SEL_W-1:0]  sel, sel_n, nxt;
  logic [1:0]        settle_cnt, settle_cnt_n;
  logic [NPORTS-1:0] port_sel_n, valid_n;
  logic              disch_d, tick, boundary, cap;
  logic              phase_unused;

  assign tick         = phase[sid::PHI2_PHI1];
  assign boundary     = tick & discharge & ~disch_d;
  assign phase_unused = ^phase;

  function automatic logic [NPORTS-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NPORTS'(1) << idx;
  endfunction

  function automatic logic [SEL_W-1:0] lowest_en(input logic [NPORTS-1:0] en);
    lowest_en = '0;
    for (int i = int'(NPORTS) - 1; i >= 0; i--)
      if (en[i]) lowest_en = SEL_W'(i);
  endfunction

  // First enabled port after cur, wrapping; returns cur when it is the only candidate.
  function automatic logic [SEL_W-1:0] next_en(input logic [NPORTS-1:0] en,
                                               input logic [SEL_W-1:0]  cur);
    int unsigned idx;
    next_en = cur;
    for (int off = int'(NPORTS); off >= 1; off--) begin
      idx = (32'(cur) + 32'(off)) % NPORTS;
      if (en[idx]) next_en = SEL_W'(idx);
    end
  endfunction

  assign nxt = next_en(port_en, sel);

  // Scheduling decisions, evaluated only at discharge boundaries.
  always_comb begin
    state_n      = state;
    sel_n        = sel;
    settle_cnt_n = settle_cnt;
    port_sel_n   = port_sel;
    cap          = 1'b0;
    if (boundary) begin
      unique case (state)
        SYNC: begin
          if (|port_en) begin
            sel_n        = lowest_en(port_en);
            port_sel_n   = onehot(sel_n);
            settle_cnt_n = SETTLE_LD;
            state_n      = (SETTLE_ROUNDS > 0) ? SETTLE : MEASURE;
          end
        end
        SETTLE: begin
          settle_cnt_n = settle_cnt - 2'd1;
          if (settle_cnt_n == 2'd0) state_n = MEASURE;
        end
        MEASURE: begin
          cap = port_en[sel];
          if (port_en == '0) begin
            port_sel_n = '0;
            state_n    = SYNC;
          end else if (nxt != sel) begin
            sel_n        = nxt;
            port_sel_n   = onehot(nxt);
            settle_cnt_n = SETTLE_LD;
            state_n      = (SETTLE_ROUNDS > 0) ? SETTLE : MEASURE;
          end
        end
        default: state_n = SYNC;
      endcase
    end
    valid_n = (valid & port_en) | (cap ? onehot(sel) : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SYNC;
      sel        <= '0;
      settle_cnt <= '0;
      port_sel   <= '0;
      result     <= '0;
      valid      <= '0;
      upd        <= 1'b0;
      upd_port   <= '0;
      disch_d    <= 1'b1;
    end else begin
      valid <= valid_n;
      upd   <= cap;
      if (tick) begin
        state      <= state_n;
        sel        <= sel_n;
        settle_cnt <= settle_cnt_n;
        port_sel   <= port_sel_n;
        disch_d    <= discharge;
      end
      if (cap) begin
        upd_port <= 2'(sel);
        for (int p = 0; p < int'(NPORTS); p++)
          if (sel == SEL_W'(p)) result[16*p +: 16] <= pot_reg;
      end
    end
  end
endmodule

// File: tb/tb_sid_pot_sched.sv
// Bench for sid_pot_sched: two instances (settle 1 and settle 0) against a round-level model,
// plus directed literal checks at chosen boundaries.
module tb_sid_pot_sched;
  localparam int unsigned P  = sid::PHI2_PHI1;
  localparam int          S0 = 1;
  localparam int          S1 = 0;

  logic          clk = 1'b0;
  logic          rst;
  sid::phase_t   phase;
  logic          discharge;
  logic [1:0]    port_en;
  logic [15:0]   tab0, tab1;
  sid::pot_reg_t pot0, pot1;

  logic [1:0]  ps  [2];
  logic [31:0] res [2];
  logic [1:0]  val [2];
  logic        upd [2];
  logic [1:0]  up  [2];

  int errs = 0;
  int checks = 0;
  int upd_seen0 = 0;
  int nb = 0;

  // Model state: connected port (-1 none) and boundaries since it was connected.
  int          conn [2];
  int          age  [2];
  logic [15:0] mres [2][2];
  logic [1:0]  mval [2];
  logic        mupd [2];
  logic [1:0]  mup  [2];
  logic        mdd;

  // The paddle pot each instance sees depends on which port its mux connects.
  assign pot0 = (ps[0] == 2'b01) ? tab0 : (ps[0] == 2'b10) ? tab1 : 16'hDEAD;
  assign pot1 = (ps[1] == 2'b01) ? tab0 : (ps[1] == 2'b10) ? tab1 : 16'hDEAD;

  sid_pot_sched #(.NPORTS(2), .SETTLE_ROUNDS(S0)) u0 (
    .clk(clk), .rst(rst), .phase(phase), .discharge(discharge), .pot_reg(pot0),
    .port_en(port_en), .port_sel(ps[0]), .result(res[0]), .valid(val[0]),
    .upd(upd[0]), .upd_port(up[0]));

  sid_pot_sched #(.NPORTS(2), .SETTLE_ROUNDS(S1)) u1 (
    .clk(clk), .rst(rst), .phase(phase), .discharge(discharge), .pot_reg(pot1),
    .port_en(port_en), .port_sel(ps[1]), .result(res[1]), .valid(val[1]),
    .upd(upd[1]), .upd_port(up[1]));

  always #5 clk = ~clk;

  // phi1 strobe every other clk; discharge = bit 8 of a tick counter.
  initial begin : phase_gen
    int unsigned pcnt;
    logic t;
    pcnt = 0;
    phase = '0;
    discharge = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      t = phase[P];
      if (t) begin
        pcnt = pcnt + 1;
        discharge = pcnt[8];
      end
      phase = '0;
      phase[P] = ~t;
      phase[sid::PHI1_PHI2] = t;
    end
  end

  function automatic int settle_of(input int k);
    return (k == 0) ? S0 : S1;
  endfunction

  function automatic int other_if_en(input logic [1:0] en, input int c);
    return en[1-c] ? 1 - c : c;
  endfunction

  initial begin : model
    logic b;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int k = 0; k < 2; k++) begin
          conn[k] = -1; age[k] = 0; mres[k][0] = '0; mres[k][1] = '0;
          mval[k] = '0; mupd[k] = 1'b0; mup[k] = '0;
        end
        mdd = 1'b1;
      end else begin
        b = phase[P] && discharge && !mdd;
        if (phase[P]) mdd = discharge;
        for (int k = 0; k < 2; k++) begin
          mupd[k] = 1'b0;
          mval[k] = mval[k] & port_en;
          if (b) begin
            if (conn[k] < 0) begin
              if (port_en != 2'b00) begin
                conn[k] = port_en[0] ? 0 : 1;
                age[k] = 0;
              end
            end else begin
              age[k]++;
              if (age[k] > settle_of(k)) begin
                if (port_en[conn[k]]) begin
                  mres[k][conn[k]] = (conn[k] == 0) ? tab0 : tab1;
                  mval[k][conn[k]] = 1'b1;
                  mupd[k] = 1'b1;
                  mup[k] = 2'(conn[k]);
                end
                if (port_en == 2'b00) conn[k] = -1;
                else if (other_if_en(port_en, conn[k]) != conn[k]) begin
                  conn[k] = other_if_en(port_en, conn[k]);
                  age[k] = 0;
                end
              end
            end
          end
        end
        if (b) nb++;
      end
    end
  end

  initial begin : compare
    logic [38:0] act, exp;
    logic [1:0]  eps;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        eps = (conn[k] < 0) ? 2'b00 : (2'b01 << conn[k]);
        exp = {eps, mres[k][1], mres[k][0], mval[k], mupd[k], mup[k]};
        act = {ps[k], res[k], val[k], upd[k], up[k]};
        checks++;
        if (act !== exp) begin
          errs++;
          if (errs < 40)
            $display("FAIL model_dut%0d t=%0t got sel=%b res=%h val=%b upd=%b port=%0d want sel=%b res=%h val=%b upd=%b port=%0d",
                     k, $time, ps[k], res[k], val[k], upd[k], up[k],
                     eps, {mres[k][1], mres[k][0]}, mval[k], mupd[k], mup[k]);
        end
      end
      if (upd[0]) upd_seen0++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic wait_bnd();
    int start;
    int cyc;
    start = nb;
    cyc = 0;
    while (nb == start && cyc < 1100) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (nb == start) begin
      errs++;
      $display("FAIL bnd_timeout got=no boundary want=boundary within 1100 clks");
    end
  endtask

  initial begin : stim
    int base;
    rst = 1'b1;
    port_en = 2'b11;
    tab0 = 16'h8040;
    tab1 = 16'hF010;
    repeat (4) @(negedge clk);
    chk("rst_sel", 32'(ps[0]), 0);
    chk("rst_res", res[0], 0);
    chk("rst_valid", 32'(val[0]), 0);
    chk("rst_upd", 32'(upd[0]), 0);
    rst = 1'b0;

    wait_bnd(); // b1
    chk("b1_sel0", 32'(ps[0]), 32'h1);
    chk("b1_upd0", 32'(upd[0]), 0);
    chk("b1_sel1", 32'(ps[1]), 32'h1);
    wait_bnd(); // b2
    chk("b2_upd0", 32'(upd[0]), 0);
    chk("b2_upd1", 32'(upd[1]), 1);
    chk("b2_port1", 32'(up[1]), 0);
    chk("b2_res1_lo", 32'(res[1][15:0]), 32'h8040);
    wait_bnd(); // b3
    chk("b3_upd0", 32'(upd[0]), 1);
    chk("b3_res0_lo", 32'(res[0][15:0]), 32'h8040);
    chk("b3_port0", 32'(up[0]), 0);
    chk("b3_sel0", 32'(ps[0]), 32'h2);
    chk("b3_port1", 32'(up[1]), 1);
    chk("b3_res1_hi", 32'(res[1][31:16]), 32'hF010);
    wait_bnd(); // b4
    chk("b4_port1", 32'(up[1]), 0);
    wait_bnd(); // b5
    chk("b5_res0_hi", 32'(res[0][31:16]), 32'hF010);
    chk("b5_valid0", 32'(val[0]), 32'h3);
    chk("b5_port0", 32'(up[0]), 1);
    chk("b5_port1", 32'(up[1]), 1);

    // port1 disabled while being measured
    wait_bnd(); wait_bnd(); wait_bnd(); // b6..b8
    repeat (512) @(negedge clk);
    port_en = 2'b01;
    @(negedge clk);
    chk("t3_valid0_clr", 32'(val[0]), 32'h1);
    wait_bnd(); // b9
    chk("b9_upd0", 32'(upd[0]), 0);
    chk("b9_sel0", 32'(ps[0]), 32'h1);

    // reset ~100 ticks before a boundary, then port1 only
    repeat (824) @(negedge clk);
    port_en = 2'b10;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_sel0", 32'(ps[0]), 0);
    chk("t5_res0", res[0], 0);
    chk("t5_valid0", 32'(val[0]), 0);
    chk("t5_upd0", 32'(upd[0]), 0);
    chk("t5_port0", 32'(up[0]), 0);
    rst = 1'b0;
    wait_bnd(); // b10
    chk("b10_upd0", 32'(upd[0]), 0);
    chk("b10_upd1", 32'(upd[1]), 0);
    chk("b10_sel0", 32'(ps[0]), 32'h2);
    tab1 = 16'h5A3C;
    wait_bnd(); // b11
    chk("b11_upd0", 32'(upd[0]), 0);
    wait_bnd(); // b12
    chk("b12_upd0", 32'(upd[0]), 1);
    chk("b12_res0_hi", 32'(res[0][31:16]), 32'h5A3C);
    chk("b12_valid0", 32'(val[0]), 32'h2);
    tab1 = 16'h2277;
    wait_bnd(); // b13
    chk("b13_res0", res[0], 32'h2277_0000);
    chk("b13_sel0", 32'(ps[0]), 32'h2);

    // all ports disabled for four rounds
    port_en = 2'b00;
    base = upd_seen0;
    wait_bnd(); // b14
    chk("b14_sel0", 32'(ps[0]), 0);
    chk("b14_valid0", 32'(val[0]), 0);
    wait_bnd(); wait_bnd(); wait_bnd(); // b15..b17
    chk("t4_no_upd", 32'(upd_seen0 - base), 0);
    port_en = 2'b01;
    wait_bnd(); // b18
    chk("b18_sel0", 32'(ps[0]), 32'h1);
    chk("b18_upd0", 32'(upd[0]), 0);
    chk("b18_upd1", 32'(upd[1]), 0);
    wait_bnd(); // b19
    chk("b19_upd1", 32'(upd[1]), 1);
    wait_bnd(); // b20
    chk("b20_res0", res[0], 32'h2277_8040);
    chk("b20_valid0", 32'(val[0]), 32'h1);
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
